// File: rtl/fmac_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fmac_fifo_wr_arb
//
// Frame-granular write-side arbiter in front of the 512x64 dual-clock MAC
// FIFO. Runs entirely in the FIFO write-clock domain. Two requesters offer
// whole frames. A frame is admitted only when the FIFO has room for the
// declared length plus a guard band, so a full FIFO never splits a frame.
// Ownership rotates round-robin and is held until the end of the frame.
//
// Ports
//   clk, reset            write-domain clock, synchronous active-high reset
//   reqN_valid            requester N offers a word (first word carries len)
//   reqN_len              frame length in words, 0 = 2^LEN_W; used in IDLE
//   reqN_data, reqN_eop   data word and last-word marker
//   reqN_ready            word accepted on reqN_valid & reqN_ready
//   fifo_wrreq, fifo_data registered FIFO write port (one cycle after accept)
//   fifo_wrfull           FIFO full flag
//   fifo_wrusedw          FIFO fill level, PTR+1 bits
//   grant                 one-hot owner, 00 when nobody owns the port
//   busy                  arbiter is not in IDLE
//   len_err               one-cycle pulse when eop and the length disagree
//
// Optional build macro FMAC_WR_ARB_STATS_EN adds:
//   frm_cnt0, frm_cnt1    completed frames per requester (16 bit, wrapping)
//   err_cnt               len_err pulses (16 bit, saturating)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; arbitrate among eligible requesters each cycle
// XFER   | owner streams words; ends on eop or when length is reached
// GAP    | GAP_CYC dead cycles so fifo_wrusedw catches up before arbitrating
// ---------------------------------------------------------------------------
module fmac_fifo_wr_arb #(
   parameter int WIDTH   = 64,
   parameter int DEPTH   = 512,
   parameter int PTR     = 9,
   parameter int LEN_W   = 8,
   parameter int GUARD   = 2,
   parameter int GAP_CYC = 2
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             req0_valid,
   input  logic [LEN_W-1:0] req0_len,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req0_eop,
   output logic             req0_ready,

   input  logic             req1_valid,
   input  logic [LEN_W-1:0] req1_len,
   input  logic [WIDTH-1:0] req1_data,
   input  logic             req1_eop,
   output logic             req1_ready,

   output logic             fifo_wrreq,
   output logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_wrfull,
   input  logic [PTR:0]     fifo_wrusedw,

   output logic [1:0]       grant,
   output logic             busy,
`ifdef FMAC_WR_ARB_STATS_EN
   output logic [15:0]      frm_cnt0,
   output logic [15:0]      frm_cnt1,
   output logic [15:0]      err_cnt,
`endif
   output logic             len_err
);

   // len_eff needs one extra bit to hold 2^LEN_W; the eligibility compare
   // is done one bit wider than either operand so the guard add cannot wrap.
   localparam int LW = LEN_W + 1;
   localparam int CW = (((PTR + 1) > LW) ? (PTR + 1) : LW) + 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [PTR:0]    DEPTH_V  = (PTR + 1)'(DEPTH);
   localparam logic [LW-1:0]   LEN_MAX  = LW'(2 ** LEN_W);
   localparam logic [CW-1:0]   GUARD_V  = CW'(GUARD);
   localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t            state;
   logic              ptr;
   logic [LW-1:0]     len_q;
   logic [LW-1:0]     cnt;
   logic [GW-1:0]     gap_cnt;

   logic [PTR:0]      free;
   logic [LW-1:0]     len_eff0;
   logic [LW-1:0]     len_eff1;
   logic [CW-1:0]     need0;
   logic [CW-1:0]     need1;
   logic              elig0;
   logic              elig1;
   logic [1:0]        pick;

   logic              hs;
   logic              sel_eop;
   logic [WIDTH-1:0]  sel_data;
   logic [LW-1:0]     cnt_nxt;
   logic              at_lim;
   logic              frm_end;

   // ------------------------------------------------------------------
   // Admission
   // ------------------------------------------------------------------
   assign len_eff0 = (req0_len == '0) ? LEN_MAX : LW'(req0_len);
   assign len_eff1 = (req1_len == '0) ? LEN_MAX : LW'(req1_len);

   // wrfull overrides the level so a stale wrusedw never admits a frame.
   assign free  = fifo_wrfull ? '0 : (DEPTH_V - fifo_wrusedw);

   assign need0 = CW'(len_eff0) + GUARD_V;
   assign need1 = CW'(len_eff1) + GUARD_V;
   assign elig0 = req0_valid & (CW'(free) >= need0);
   assign elig1 = req1_valid & (CW'(free) >= need1);

   // A valid-but-too-large preferred frame blocks the other requester, so a
   // big frame cannot be starved by a stream of small ones.
   always_comb begin
      pick = 2'b00;
      if (ptr == 1'b0) begin
         if (elig0)
            pick = 2'b01;
         else if (!req0_valid && elig1)
            pick = 2'b10;
      end else begin
         if (elig1)
            pick = 2'b10;
         else if (!req1_valid && elig0)
            pick = 2'b01;
      end
   end

   // ------------------------------------------------------------------
   // Transfer datapath
   // ------------------------------------------------------------------
   // grant is only non-zero in XFER, so ready is naturally low elsewhere.
   assign req0_ready = grant[0] & ~fifo_wrfull;
   assign req1_ready = grant[1] & ~fifo_wrfull;

   assign hs       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign sel_eop  = grant[1] ? req1_eop  : req0_eop;
   assign sel_data = grant[1] ? req1_data : req0_data;

   assign cnt_nxt  = cnt + LW'(1);
   assign at_lim   = (cnt_nxt == len_q);
   assign frm_end  = (state == ST_XFER) & hs & (sel_eop | at_lim);

   assign busy     = (state != ST_IDLE);

   // ------------------------------------------------------------------
   // Controller
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         grant      <= 2'b00;
         ptr        <= 1'b0;
         len_q      <= '0;
         cnt        <= '0;
         gap_cnt    <= '0;
         fifo_wrreq <= 1'b0;
         fifo_data  <= '0;
         len_err    <= 1'b0;
      end else begin
         fifo_wrreq <= 1'b0;
         len_err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick != 2'b00) begin
                  grant <= pick;
                  len_q <= pick[1] ? len_eff1 : len_eff0;
                  cnt   <= '0;
                  state <= ST_XFER;
               end
            end

            ST_XFER: begin
               if (hs) begin
                  fifo_wrreq <= 1'b1;
                  fifo_data  <= sel_data;
                  cnt        <= cnt_nxt;
                  if (sel_eop | at_lim) begin
                     // Exactly one end condition means the declared length
                     // and the eop marker disagree.
                     len_err <= sel_eop ^ at_lim;
                     grant   <= 2'b00;
                     ptr     <= grant[0];
                     gap_cnt <= GAP_LOAD;
                     state   <= ST_GAP;
                  end
               end
            end

            ST_GAP: begin
               if (gap_cnt == '0)
                  state <= ST_IDLE;
               else
                  gap_cnt <= gap_cnt - GW'(1);
            end

            default: begin
               state <= ST_IDLE;
               grant <= 2'b00;
            end
         endcase
      end
   end

`ifdef FMAC_WR_ARB_STATS_EN
   // ------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         frm_cnt0 <= '0;
         frm_cnt1 <= '0;
         err_cnt  <= '0;
      end else begin
         if (frm_end && grant[0])
            frm_cnt0 <= frm_cnt0 + 16'd1;
         if (frm_end && grant[1])
            frm_cnt1 <= frm_cnt1 + 16'd1;
         if (len_err && (err_cnt != 16'hffff))
            err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule
